// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Issues one request/ready bus transaction per load/store, generates byte
// enables and lane-replicated store data, extracts and extends load data, and
// stalls the pipeline until the access completes.
// Optional feature: define MEM_ADDR_CHECK_EN to flag misaligned half/word
// accesses on MEM_AddrErr and suppress their issue.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemByte,
    input  logic        MEM_MemHalf,
    input  logic        MEM_MemSignExt,
    input  logic [31:0] MEM_ALU_Result,
    input  logic [31:0] MEM_ReadData2,
    input  logic        MEM_Flush,
    input  logic        WB_Stall,
    input  logic        DataMem_Ready,
    input  logic [31:0] DataMem_ReadData,
    output logic        DataMem_Req,
    output logic        DataMem_Write,
    output logic [29:0] DataMem_Addr,
    output logic [31:0] DataMem_WriteData,
    output logic [3:0]  DataMem_ByteEn,
    output logic [31:0] MEM_ReadData,
    output logic        MEM_Stall,
    output logic        MEM_AddrErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } accessSize_t;

    state_t      state;
    state_t      nextState;
    logic        addrErr;
    logic        access;
    logic        issue;
    logic        complete;

    accessSize_t issueSize;
    logic [3:0]  issueByteEn;
    logic [31:0] issueWriteData;

    // Transaction fields captured at issue; they drive the bus while waiting
    // and steer load extraction once the access is done.
    logic        writeQ;
    logic [29:0] addrQ;
    logic [1:0]  offsetQ;
    logic [3:0]  byteEnQ;
    logic [31:0] writeDataQ;
    accessSize_t sizeQ;
    logic        signExtQ;
    logic [31:0] rdata_q;

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadData;

    // Misaligned-access detection (only meaningful when a memory op is present)
`ifdef MEM_ADDR_CHECK_EN
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        addrErr = 1'b0;
        if (MEM_MemRead | MEM_MemWrite) begin
            if (!MEM_MemByte && MEM_MemHalf && MEM_ALU_Result[0]) begin
                addrErr = 1'b1;
            end else if (!MEM_MemByte && !MEM_MemHalf && (MEM_ALU_Result[1:0] != 2'b00)) begin
                addrErr = 1'b1;
            end
        end
    end
`else
    assign addrErr = 1'b0;
`endif

    assign MEM_AddrErr = addrErr;
    assign access      = (MEM_MemRead | MEM_MemWrite) & ~MEM_Flush & ~addrErr;
    assign issue       = (state == IDLE) & access;
    assign complete    = (issue | (state == WAIT)) & DataMem_Ready;

    // Decode access size; byte wins when both byte and half are set
    always_comb begin
        issueSize = SIZE_WORD;
        if (MEM_MemByte) begin
            issueSize = SIZE_BYTE;
        end else if (MEM_MemHalf) begin
            issueSize = SIZE_HALF;
        end
    end

    // Byte enables and lane-replicated store data for the instruction being issued
    always_comb begin
        issueByteEn    = 4'b1111;
        issueWriteData = MEM_ReadData2;
        case (issueSize)
            SIZE_BYTE: begin
                issueByteEn    = 4'b0001 << MEM_ALU_Result[1:0];
                issueWriteData = {4{MEM_ReadData2[7:0]}};
            end
            SIZE_HALF: begin
                issueByteEn    = MEM_ALU_Result[1] ? 4'b1100 : 4'b0011;
                issueWriteData = {2{MEM_ReadData2[15:0]}};
            end
            default: begin
                issueByteEn    = 4'b1111;
                issueWriteData = MEM_ReadData2;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: issue from IDLE, wait for Ready, hold DONE under WB_Stall
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (access) begin
                    nextState = DataMem_Ready ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (DataMem_Ready) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!WB_Stall) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Capture transaction fields at issue and the bus read word on completion
    always_ff @(posedge clk) begin
        // NOTE: the read-data holding register is reset along with the control
        // flops, so MEM_ReadData is a known value straight out of reset.
        if (rst) begin
            writeQ     <= 1'b0;
            addrQ      <= '0;
            offsetQ    <= '0;
            byteEnQ    <= '0;
            writeDataQ <= '0;
            sizeQ      <= SIZE_WORD;
            signExtQ   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (issue) begin
                writeQ     <= MEM_MemWrite;
                addrQ      <= MEM_ALU_Result[31:2];
                offsetQ    <= MEM_ALU_Result[1:0];
                byteEnQ    <= issueByteEn;
                writeDataQ <= issueWriteData;
                sizeQ      <= issueSize;
                signExtQ   <= MEM_MemSignExt;
            end
            if (complete) begin
                rdata_q <= DataMem_ReadData;
            end
        end
    end

    // Load extraction from the held read word using the issue-time size/offset
    always_comb begin
        laneByte = rdata_q[7:0];
        case (offsetQ)
            2'd1:    laneByte = rdata_q[15:8];
            2'd2:    laneByte = rdata_q[23:16];
            2'd3:    laneByte = rdata_q[31:24];
            default: laneByte = rdata_q[7:0];
        endcase
        laneHalf = offsetQ[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (sizeQ)
            SIZE_BYTE: loadData = {{24{signExtQ & laneByte[7]}}, laneByte};
            SIZE_HALF: loadData = {{16{signExtQ & laneHalf[15]}}, laneHalf};
            default:   loadData = rdata_q;
        endcase
    end

    // Output decode: live fields at issue, captured fields while waiting,
    // load result only in DONE
    always_comb begin
        DataMem_Req       = 1'b0;
        DataMem_Write     = 1'b0;
        DataMem_Addr      = '0;
        DataMem_WriteData = '0;
        DataMem_ByteEn    = '0;
        MEM_ReadData      = '0;
        MEM_Stall         = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    DataMem_Req       = 1'b1;
                    DataMem_Write     = MEM_MemWrite;
                    DataMem_Addr      = MEM_ALU_Result[31:2];
                    DataMem_WriteData = issueWriteData;
                    DataMem_ByteEn    = issueByteEn;
                    MEM_Stall         = 1'b1;
                end
            end
            WAIT: begin
                DataMem_Req       = 1'b1;
                DataMem_Write     = writeQ;
                DataMem_Addr      = addrQ;
                DataMem_WriteData = writeDataQ;
                DataMem_ByteEn    = byteEnQ;
                MEM_Stall         = 1'b1;
            end
            DONE: begin
                MEM_ReadData = loadData;
            end
            default: begin
                DataMem_Req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge. Expected bus transactions and
// load results are queued when an access is driven and popped on completion.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic        MEM_MemByte;
    logic        MEM_MemHalf;
    logic        MEM_MemSignExt;
    logic [31:0] MEM_ALU_Result;
    logic [31:0] MEM_ReadData2;
    logic        MEM_Flush;
    logic        WB_Stall;
    logic        DataMem_Ready;
    logic [31:0] DataMem_ReadData;
    logic        DataMem_Req;
    logic        DataMem_Write;
    logic [29:0] DataMem_Addr;
    logic [31:0] DataMem_WriteData;
    logic [3:0]  DataMem_ByteEn;
    logic [31:0] MEM_ReadData;
    logic        MEM_Stall;
    logic        MEM_AddrErr;

    typedef struct packed {
        logic        write;
        logic [29:0] addr;
        logic [3:0]  byteEn;
        logic [31:0] wdata;
    } busItem_t;

    busItem_t    expBus[$];
    logic [31:0] expRead[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          txCount     = 0;

    mem_access_unit dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_MemRead       (MEM_MemRead),
        .MEM_MemWrite      (MEM_MemWrite),
        .MEM_MemByte       (MEM_MemByte),
        .MEM_MemHalf       (MEM_MemHalf),
        .MEM_MemSignExt    (MEM_MemSignExt),
        .MEM_ALU_Result    (MEM_ALU_Result),
        .MEM_ReadData2     (MEM_ReadData2),
        .MEM_Flush         (MEM_Flush),
        .WB_Stall          (WB_Stall),
        .DataMem_Ready     (DataMem_Ready),
        .DataMem_ReadData  (DataMem_ReadData),
        .DataMem_Req       (DataMem_Req),
        .DataMem_Write     (DataMem_Write),
        .DataMem_Addr      (DataMem_Addr),
        .DataMem_WriteData (DataMem_WriteData),
        .DataMem_ByteEn    (DataMem_ByteEn),
        .MEM_ReadData      (MEM_ReadData),
        .MEM_Stall         (MEM_Stall),
        .MEM_AddrErr       (MEM_AddrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed bus transactions (request accepted by the bus)
    always @(negedge clk) begin
        if (!rst && DataMem_Req && DataMem_Ready) txCount++;
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic setNop;
        MEM_MemRead      = 1'b0;
        MEM_MemWrite     = 1'b0;
        MEM_MemByte      = 1'b0;
        MEM_MemHalf      = 1'b0;
        MEM_MemSignExt   = 1'b0;
        MEM_ALU_Result   = 32'h0;
        MEM_ReadData2    = 32'h0;
        MEM_Flush        = 1'b0;
        WB_Stall         = 1'b0;
        DataMem_Ready    = 1'b0;
        DataMem_ReadData = 32'h0;
    endtask

    // Reference load extraction built from a byte array
    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] off,
                                            input logic byt, input logic half, input logic sext);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (byt) return {{24{sext & b[off][7]}}, b[off]};
        if (half) begin
            h = off[1] ? {b[3], b[2]} : {b[1], b[0]};
            return {{16{sext & h[15]}}, h};
        end
        return w;
    endfunction

    // One complete access: issue, waitCycles WAIT cycles (Ready in the last),
    // then DONE held for wbStallCycles extra cycles, then back to idle.
    task automatic runAccess(input string name, input logic rd, input logic wr,
                             input logic byt, input logic half, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] busWord, input int waitCycles,
                             input int wbStallCycles, input logic flushWait,
                             input logic [31:0] expWord, input logic [3:0] expBe,
                             input logic [31:0] expWd);
        busItem_t    got;
        busItem_t    done;
        logic [31:0] heldRd;
        int          stalls;
        int          tx0;
        expBus.push_back({wr, addr[31:2], expBe, expWd});
        if (rd) expRead.push_back(expWord);
        tx0    = txCount;
        stalls = 0;
        heldRd = 32'h0;
        for (int c = 0; c <= waitCycles; c++) begin
            nextCycle;
            MEM_MemRead      = rd;
            MEM_MemWrite     = wr;
            MEM_MemByte      = byt;
            MEM_MemHalf      = half;
            MEM_MemSignExt   = (c == 0) ? sext : ~sext;
            MEM_ALU_Result   = (c == 0) ? addr : (addr ^ 32'hFFFF_0000);
            MEM_ReadData2    = (c == 0) ? wdata : ~wdata;
            MEM_Flush        = (c > 0) ? flushWait : 1'b0;
            DataMem_Ready    = (c == waitCycles);
            DataMem_ReadData = (c == waitCycles) ? busWord : ~busWord;
            @(negedge clk);
            if (MEM_Stall) stalls++;
            got = {DataMem_Write, DataMem_Addr, DataMem_ByteEn, DataMem_WriteData};
            vectors++;
            if (DataMem_Req !== 1'b1 || MEM_AddrErr !== 1'b0 || got !== expBus[0]) begin
                miscompares++;
                $display("FAIL %s bus cycle %0d: req=%b err=%b got=%h expected=%h",
                         name, c, DataMem_Req, MEM_AddrErr, got, expBus[0]);
            end
            if (c == waitCycles) done = expBus.pop_front();
        end
        for (int s = 0; s <= wbStallCycles; s++) begin
            nextCycle;
            MEM_MemSignExt   = sext;
            MEM_ALU_Result   = addr;
            MEM_ReadData2    = wdata;
            MEM_Flush        = 1'b0;
            DataMem_Ready    = 1'b0;
            DataMem_ReadData = 32'hBAD0_BAD0;
            WB_Stall         = (s < wbStallCycles);
            @(negedge clk);
            vectors++;
            if ({DataMem_Req, MEM_Stall} !== 2'b00) begin
                miscompares++;
                $display("FAIL %s done cycle %0d: req=%b stall=%b expected 0 0",
                         name, s, DataMem_Req, MEM_Stall);
            end
            if (rd) begin
                if (s == 0) heldRd = expRead.pop_front();
                vectors++;
                if (MEM_ReadData !== heldRd) begin
                    miscompares++;
                    $display("FAIL %s readdata cycle %0d: got=%h expected=%h",
                             name, s, MEM_ReadData, heldRd);
                end
            end
        end
        nextCycle;
        setNop;
        @(negedge clk);
        #1;
        vectors++;
        if ({DataMem_Req, MEM_Stall, MEM_ReadData} !== 34'h0) begin
            miscompares++;
            $display("FAIL %s idle after: req=%b stall=%b rd=%h expected all 0",
                     name, DataMem_Req, MEM_Stall, MEM_ReadData);
        end
        vectors++;
        if (txCount - tx0 != 1) begin
            miscompares++;
            $display("FAIL %s transactions: got=%0d expected=1", name, txCount - tx0);
        end
        vectors++;
        if (stalls != waitCycles + 1) begin
            miscompares++;
            $display("FAIL %s stall cycles: got=%0d expected=%0d", name, stalls, waitCycles + 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        setNop;
        nextCycle;
        nextCycle;
        @(negedge clk);
        vectors++;
        if ({DataMem_Req, DataMem_Write, DataMem_Addr, DataMem_WriteData, DataMem_ByteEn,
             MEM_ReadData, MEM_Stall, MEM_AddrErr} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: req=%b wr=%b addr=%h wd=%h be=%b rd=%h stall=%b err=%b expected all 0",
                     DataMem_Req, DataMem_Write, DataMem_Addr, DataMem_WriteData, DataMem_ByteEn,
                     MEM_ReadData, MEM_Stall, MEM_AddrErr);
        end
        nextCycle;
        rst = 1'b0;
    endtask

    task automatic test_word_store;
        runAccess("word_store", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF,
                  32'h0, 0, 0, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte_load;
        runAccess("byte_load_sext", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h1122_3344,
                  32'h80FF_1234, 3, 0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h4444_4444);
        runAccess("byte_load_zext", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h1122_3344,
                  32'h80FF_1234, 3, 0, 1'b0, 32'h0000_0080, 4'b1000, 32'h4444_4444);
    endtask

    task automatic test_half_store;
        runAccess("half_store_flush_in_wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0022,
                  32'h0000_ABCD, 32'h0, 1, 0, 1'b1, 32'h0, 4'b1100, 32'hABCD_ABCD);
    endtask

    task automatic test_wb_stall;
        runAccess("load_wb_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,
                  32'h1234_5678, 0, 2, 1'b0, 32'h1234_5678, 4'b1111, 32'h0);
        runAccess("store_wb_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0205, 32'h0000_00A5,
                  32'h0, 1, 2, 1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
    endtask

    task automatic test_extract_patterns;
        logic [31:0] w;
        logic [31:0] a;
        logic        s;
        for (int off = 0; off < 4; off++) begin
            w = $urandom;
            s = off[0];
            a = 32'h0000_1000 | off;
            runAccess($sformatf("byte_off%0d", off), 1'b1, 1'b0, 1'b1, 1'b0, s, a, 32'h0, w,
                      off % 3, 0, 1'b0, refLoad(w, a[1:0], 1'b1, 1'b0, s),
                      4'b0001 << off, 32'h0);
        end
        runAccess("half_lo_sext", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0,
                  32'h1234_9ABC, 1, 0, 1'b0, 32'hFFFF_9ABC, 4'b0011, 32'h0);
        runAccess("half_hi_sext", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'h0,
                  32'hF234_1ABC, 0, 0, 1'b0, 32'hFFFF_F234, 4'b1100, 32'h0);
        runAccess("half_hi_zext", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0302, 32'h0,
                  32'hF234_1ABC, 2, 0, 1'b0, 32'h0000_F234, 4'b1100, 32'h0);
        runAccess("byte_and_half", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0301, 32'h0000_5A7E,
                  32'h0000_7F00, 0, 0, 1'b0, 32'h0000_007F, 4'b0010, 32'h7E7E_7E7E);
    endtask

    task automatic test_addr_check;
`ifdef MEM_ADDR_CHECK_EN
        int tx0;
        tx0 = txCount;
        for (int c = 0; c < 2; c++) begin
            nextCycle;
            MEM_MemRead    = 1'b1;
            MEM_MemHalf    = (c == 1);
            MEM_ALU_Result = (c == 0) ? 32'h0000_0102 : 32'h0000_0101;
            DataMem_Ready  = 1'b1;
            @(negedge clk);
            vectors++;
            if ({MEM_AddrErr, DataMem_Req, MEM_Stall} !== 3'b100) begin
                miscompares++;
                $display("FAIL misaligned %0d: err=%b req=%b stall=%b expected 1 0 0",
                         c, MEM_AddrErr, DataMem_Req, MEM_Stall);
            end
        end
        nextCycle;
        setNop;
        @(negedge clk);
        #1;
        vectors++;
        if (txCount != tx0) begin
            miscompares++;
            $display("FAIL misaligned transactions: got=%0d expected=0", txCount - tx0);
        end
`else
        runAccess("unaligned_word_load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0,
                  32'hCAFE_F00D, 0, 0, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0);
        runAccess("unaligned_half_load", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0103, 32'h0,
                  32'hCAFE_F00D, 0, 0, 1'b0, 32'h0000_CAFE, 4'b1100, 32'h0);
`endif
    endtask

    task automatic test_flush;
        int tx0;
        tx0 = txCount;
        for (int c = 0; c < 2; c++) begin
            nextCycle;
            MEM_MemWrite   = 1'b1;
            MEM_ALU_Result = 32'h0000_0100;
            MEM_ReadData2  = 32'h1234_5678;
            MEM_Flush      = 1'b1;
            DataMem_Ready  = 1'b1;
            @(negedge clk);
            vectors++;
            if ({DataMem_Req, MEM_Stall} !== 2'b00) begin
                miscompares++;
                $display("FAIL flush idle %0d: req=%b stall=%b expected 0 0", c, DataMem_Req, MEM_Stall);
            end
        end
        nextCycle;
        setNop;
        @(negedge clk);
        #1;
        vectors++;
        if (txCount != tx0) begin
            miscompares++;
            $display("FAIL flush transactions: got=%0d expected=0", txCount - tx0);
        end
    endtask

    task automatic test_reset_in_wait;
        int tx0;
        tx0 = txCount;
        nextCycle;
        MEM_MemRead    = 1'b1;
        MEM_ALU_Result = 32'h0000_0400;
        DataMem_Ready  = 1'b0;
        nextCycle;
        @(negedge clk);
        vectors++;
        if ({DataMem_Req, MEM_Stall} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_in_wait pre: req=%b stall=%b expected 1 1", DataMem_Req, MEM_Stall);
        end
        nextCycle;
        rst = 1'b1;
        setNop;
        nextCycle;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({DataMem_Req, DataMem_Write, DataMem_Addr, DataMem_WriteData, DataMem_ByteEn,
             MEM_ReadData, MEM_Stall, MEM_AddrErr} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_wait outputs: req=%b addr=%h be=%b rd=%h stall=%b expected all 0",
                     DataMem_Req, DataMem_Addr, DataMem_ByteEn, MEM_ReadData, MEM_Stall);
        end
        #1;
        vectors++;
        if (txCount != tx0) begin
            miscompares++;
            $display("FAIL reset_in_wait transactions: got=%0d expected=0", txCount - tx0);
        end
        runAccess("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0,
                  32'h0BAD_CAFE, 0, 0, 1'b0, 32'h0BAD_CAFE, 4'b1111, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        setNop;
        test_reset;
        test_word_store;
        test_byte_load;
        test_half_store;
        test_wb_stall;
        test_extract_patterns;
        test_addr_check;
        test_flush;
        test_reset_in_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit between the EXE/MEM and MEM/WB pipeline registers. It takes the registered memory controls, address (ALU result) and store data, and runs a request/ready transaction on the data-memory bus. It also generates byte enables, store lane replication and load extraction with sign or zero extension. It holds the pipeline with `MEM_Stall` until the access completes and presents `MEM_ReadData` to the MEM/WB register.

## Interface
Parameters:
- none; widths are fixed at 32-bit data, 30-bit word address, 4 byte lanes.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MEM_MemRead`  in  1  load in MEM stage.
- `MEM_MemWrite`  in  1  store in MEM stage.
- `MEM_MemByte`  in  1  byte-sized access.
- `MEM_MemHalf`  in  1  halfword-sized access; neither byte nor half means word.
- `MEM_MemSignExt`  in  1  sign-extend sub-word loads; 0 means zero-extend.
- `MEM_ALU_Result`  in  32  effective byte address.
- `MEM_ReadData2`  in  32  store data, right-justified.
- `MEM_Flush`  in  1  kill the MEM-stage instruction; suppresses issue.
- `WB_Stall`  in  1  downstream hold; completed result must be retained.
- `DataMem_Ready`  in  1  bus completes the access this cycle.
- `DataMem_ReadData`  in  32  bus read word; valid when Ready=1.
- `DataMem_Req`  out  1  access request.
- `DataMem_Write`  out  1  1 for store, 0 for load.
- `DataMem_Addr`  out  30  word address, `MEM_ALU_Result[31:2]`.
- `DataMem_WriteData`  out  32  lane-replicated store data.
- `DataMem_ByteEn`  out  4  active lanes; little-endian, lane n holds byte address offset n.
- `MEM_ReadData`  out  32  aligned and extended load result.
- `MEM_Stall`  out  1  access in progress; holds EXE/MEM and upstream.
- `MEM_AddrErr`  out  1  misaligned access (see Configuration).

## Operation
- `access` = (`MEM_MemRead` | `MEM_MemWrite`) & ~`MEM_Flush` & ~`MEM_AddrErr`.
- FSM states:
  - **IDLE:**
    - If `access`: `DataMem_Req`=1, `MEM_Stall`=1.
    - If `DataMem_Ready`=1 in the same cycle: latch the read word into `rdata_q` and go to DONE.
    - Otherwise go to WAIT.
  - **WAIT:**
    - `DataMem_Req`=1, `MEM_Stall`=1.
    - Addr, Write, ByteEn and WriteData come from registers captured at issue and stay stable while waiting.
    - On Ready, latch `rdata_q` and go to DONE.
    - `MEM_Flush` is ignored in WAIT: the transaction completes, but the result is discarded downstream.
  - **DONE:**
    - `DataMem_Req`=0, `MEM_Stall`=0, `MEM_ReadData` = extract(`rdata_q`).
    - If `WB_Stall`: stay in DONE with no reissue and `MEM_ReadData` held.
    - Otherwise go to IDLE.
- Byte enables and store data by access size:
  - Byte: ByteEn = 1<<addr[1:0]; WriteData = {4{data[7:0]}}.
  - Half: ByteEn = addr[1] ? 4'b1100 : 4'b0011; WriteData = {2{data[15:0]}}.
  - Word: ByteEn = 4'b1111; WriteData = data.
- Load extraction:
  - Byte: select lane addr[1:0], then extend bit 7 if SignExt, else zero-extend.
  - Half: select the half at addr[1], extend bit 15 likewise.
  - Word: pass through unchanged.
- The size and SignExt fields used for extraction are those captured at issue.
- A cycle with no memory op: no request, `MEM_Stall`=0, `MEM_ReadData` = 0.
- Byte and Half both set: treated as byte.

## Timing
- Reset values: state IDLE, `rdata_q`=0, every output 0.
- Reset mid-WAIT returns to IDLE and drops Req in the next cycle; the bus must tolerate an abandoned request.
- Minimum access: 1 stall cycle (IDLE with Ready=1), then result valid in DONE; MEM/WB captures it at the end of the DONE cycle.
- Each cycle Ready is low in WAIT adds one stall cycle.
- Exactly one bus transaction per memory instruction; stores never repeat, even under `WB_Stall`.
- `MEM_AddrErr` is combinational from the current inputs and is asserted only when Read or Write is set.

## Configuration
- Macro `MEM_ADDR_CHECK_EN`.
- **Defined:**
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, asserts `MEM_AddrErr`.
  - No request is issued and `MEM_Stall` stays 0.
- **Undefined:**
  - `MEM_AddrErr` is tied 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, Ready in the issue cycle -> Req=1, Write=1, Addr=0x40, ByteEn=1111, one stall cycle, then DONE with no reissue.
- Byte load, addr 0x103, bus word 0x80FF_1234, SignExt=1, Ready after 3 WAIT cycles -> stall lasts 4 cycles, `MEM_ReadData`=0xFFFFFF80; repeat with SignExt=0 -> 0x00000080.
- Half store, addr 0x22, data 0x0000ABCD -> ByteEn=1100, WriteData=0xABCDABCD.
- Load completes while `WB_Stall`=1 for 2 cycles -> state stays DONE, `MEM_ReadData` stable, Req stays 0, exactly one transaction.
- With `MEM_ADDR_CHECK_EN`, word load at 0x102 -> `MEM_AddrErr`=1, Req=0, Stall=0; without the macro -> Addr=0x40, normal access.
- `rst` asserted in WAIT -> next cycle all outputs 0 and state IDLE; `MEM_Flush` with a store in IDLE -> Req stays 0.
